// File: rtl/gmii_rx_framer.sv
// GMII receive framer: strips preamble/SFD, delimits frames, checks length.
// Optional FCS check is built when RX_CRC_CHECK_EN is defined.
module gmii_rx_framer #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [7:0]  gmii_rxd,
  input  logic        gmii_rx_dv,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_sof,
  output logic        out_eof,
  output logic        out_err_crc,
  output logic        out_err_len,
  output logic [10:0] out_len,
  output logic [15:0] cnt_ok,
  output logic [15:0] cnt_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRE,
    S_DATA,
    S_DROP
  } state_t;

  localparam logic [10:0] LEN_SAT = 11'h7FF;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_hold;
  logic [10:0] r_len;
  logic        w_cap;
  logic        w_emit;
  logic        w_eof;
  logic        w_sof;
  logic        w_len_bad;
  logic        w_crc_err;
  int          w_len_int;

  // State register
  always_ff @(posedge sys_clk) begin
    if (sys_rst) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (gmii_rx_dv && gmii_rxd == 8'h55) w_next = S_PRE;
        else if (gmii_rx_dv)                 w_next = S_DROP;
      end
      S_PRE: begin
        if (!gmii_rx_dv)            w_next = S_IDLE;
        else if (gmii_rxd == 8'h55) w_next = S_PRE;
        else if (gmii_rxd == 8'hD5) w_next = S_DATA;
        else                        w_next = S_DROP;
      end
      S_DATA: begin
        if (!gmii_rx_dv) w_next = S_IDLE;
      end
      S_DROP: begin
        if (!gmii_rx_dv) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode: a held byte leaves when the next arrives or dv drops
  always_comb begin
    w_cap  = (r_state == S_DATA) && gmii_rx_dv;
    w_emit = (r_state == S_DATA) && (r_len != 11'd0);
    w_eof  = w_emit && !gmii_rx_dv;
    w_sof  = w_emit && (r_len == 11'd1);
  end

  assign w_len_int = int'(r_len);
  assign w_len_bad = (w_len_int < MIN_LEN) || (w_len_int > MAX_LEN);

`ifdef RX_CRC_CHECK_EN
  logic [31:0] r_crc;

  function automatic logic [31:0] crc_byte(
    input logic [31:0] c_in,
    input logic [7:0]  b
  );
    logic [31:0] c;
    c = c_in ^ {24'd0, b};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) c = (c >> 1) ^ 32'hEDB88320;
      else      c = c >> 1;
    end
    return c;
  endfunction

  // Running CRC over every DATA byte, re-seeded outside DATA
  always_ff @(posedge sys_clk) begin
    if (sys_rst)                r_crc <= '0;
    else if (w_cap)             r_crc <= crc_byte(r_crc, gmii_rxd);
    else if (r_state != S_DATA) r_crc <= 32'hFFFFFFFF;
  end

  assign w_crc_err = (r_crc != 32'hDEBB20E3);
`else
  assign w_crc_err = 1'b0;
`endif

  // Hold register and saturating length counter
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_hold <= '0;
      r_len  <= '0;
    end else if (w_cap) begin
      r_hold <= gmii_rxd;
      if (r_len != LEN_SAT) r_len <= r_len + 11'd1;
    end else begin
      r_len <= '0;
    end
  end

  // Registered frame outputs
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_sof     <= 1'b0;
      out_eof     <= 1'b0;
      out_err_crc <= 1'b0;
      out_err_len <= 1'b0;
      out_len     <= '0;
    end else begin
      out_valid <= w_emit;
      out_sof   <= w_sof;
      out_eof   <= w_eof;
      if (w_emit) out_data <= r_hold;
      if (w_eof) begin
        out_len     <= r_len;
        out_err_len <= w_len_bad;
        out_err_crc <= w_crc_err;
      end else begin
        out_err_len <= 1'b0;
        out_err_crc <= 1'b0;
      end
    end
  end

  // Frame statistics, updated once per completed frame
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt_ok  <= '0;
      cnt_err <= '0;
    end else if (w_eof) begin
      if (w_len_bad || w_crc_err) cnt_err <= cnt_err + 16'd1;
      else                        cnt_ok  <= cnt_ok + 16'd1;
    end
  end

endmodule

// File: tb/tb_gmii_rx_framer.sv
// Testbench for gmii_rx_framer: directed frames, per-cycle model compare.
// Honours RX_CRC_CHECK_EN the same way the design does.
module tb_gmii_rx_framer;

  localparam int MAXC = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rxd;
  logic        dv;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_sof;
  logic        out_eof;
  logic        out_err_crc;
  logic        out_err_len;
  logic [10:0] out_len;
  logic [15:0] cnt_ok;
  logic [15:0] cnt_err;

  always #5 clk = ~clk;

  gmii_rx_framer dut (
    .sys_clk     (clk),
    .sys_rst     (rst),
    .gmii_rxd    (rxd),
    .gmii_rx_dv  (dv),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_sof     (out_sof),
    .out_eof     (out_eof),
    .out_err_crc (out_err_crc),
    .out_err_len (out_err_len),
    .out_len     (out_len),
    .cnt_ok      (cnt_ok),
    .cnt_err     (cnt_err)
  );

  // stimulus timeline: entry c is sampled at clock edge c
  logic        s_dv  [MAXC];
  logic        s_rst [MAXC];
  logic [7:0]  s_d   [MAXC];
  int          n = 0;

  // expected outputs visible just after edge c
  logic        e_v   [MAXC];
  logic        e_sof [MAXC];
  logic        e_eof [MAXC];
  logic        e_el  [MAXC];
  logic        e_ec  [MAXC];
  logic [7:0]  e_d   [MAXC];
  logic [10:0] e_len [MAXC];
  logic [15:0] e_ok  [MAXC];
  logic [15:0] e_er  [MAXC];

  logic [7:0]  sb[$];
  int          sc[$];
  int          obs_len[$];
  int          obs_el[$];
  int          obs_valid = 0;

  int checks = 0;
  int failures = 0;

  function automatic logic [31:0] crc_upd(input logic [31:0] c_in,
                                          input logic [7:0] b);
    logic [31:0] c;
    c = c_in ^ {24'd0, b};
    for (int i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  task automatic chk(input string nm, input int cyc,
                     input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 30)
        $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
    end
  endtask

  task automatic add(input logic v, input logic [7:0] d, input logic r);
    s_dv[n]  = v;
    s_d[n]   = d;
    s_rst[n] = r;
    n++;
  endtask

  task automatic add_frame(input int len, input int flip_at,
                           input int rst_at);
    logic [7:0]  f[$];
    logic [31:0] c;
    logic [7:0]  b;
    c = 32'hFFFFFFFF;
    for (int j = 0; j < len - 4; j++) begin
      b = 8'(j * 7 + 3);
      f.push_back(b);
      c = crc_upd(c, b);
    end
    c = ~c;
    f.push_back(c[7:0]);
    f.push_back(c[15:8]);
    f.push_back(c[23:16]);
    f.push_back(c[31:24]);
    if (flip_at >= 0) f[flip_at] = f[flip_at] ^ 8'h04;
    for (int j = 0; j < 7; j++) add(1'b1, 8'h55, 1'b0);
    add(1'b1, 8'hD5, 1'b0);
    for (int j = 0; j < f.size(); j++)
      add(1'b1, f[j], (j == rst_at));
    for (int j = 0; j < 4; j++) add(1'b0, 8'h00, 1'b0);
  endtask

  // one dv burst (in sb/sc) ended at term_c by dv low or by reset
  task automatic eval_seg(input int term_c, input logic aborted);
    int          p;
    int          first;
    int          m;
    int          due;
    int          len;
    logic        el;
    logic        ec;
    logic [31:0] c;
    logic [31:0] fcs;
    if (sb[0] != 8'h55) return;
    p = 0;
    while (p < sb.size() && sb[p] == 8'h55) p++;
    if (p == sb.size() || sb[p] != 8'hD5) return;
    first = p + 1;
    m = sb.size() - first;
    if (m == 0) return;
    len = (m > 2047) ? 2047 : m;
    el  = (len < 64) || (len > 1518);
    ec  = 1'b0;
`ifdef RX_CRC_CHECK_EN
    if (m < 4) begin
      ec = 1'b1;
    end else begin
      c = 32'hFFFFFFFF;
      for (int j = 0; j < m - 4; j++) c = crc_upd(c, sb[first + j]);
      c = ~c;
      fcs = {sb[first + m - 1], sb[first + m - 2],
             sb[first + m - 3], sb[first + m - 4]};
      ec = (fcs != c);
    end
`else
    c = 32'd0;
    fcs = 32'd0;
    ec = (c != fcs);
`endif
    for (int j = 0; j < m; j++) begin
      due = sc[first + j] + 1;
      if (aborted && due >= term_c) continue;
      e_v[due]   = 1'b1;
      e_d[due]   = sb[first + j];
      e_sof[due] = (j == 0);
      if (j == m - 1 && !aborted) begin
        e_eof[due] = 1'b1;
        e_len[due] = 11'(len);
        e_el[due]  = el;
        e_ec[due]  = ec;
      end
    end
  endtask

  task automatic build_model();
    int   ok;
    int   er;
    logic term;
    logic ab;
    for (int c = 0; c <= n; c++) begin
      e_v[c] = 0; e_sof[c] = 0; e_eof[c] = 0; e_el[c] = 0;
      e_ec[c] = 0; e_d[c] = 0; e_len[c] = 0;
    end
    sb.delete();
    sc.delete();
    for (int c = 0; c <= n; c++) begin
      term = (c == n) || s_rst[c] || !s_dv[c];
      ab   = (c < n) && s_rst[c];
      if (term) begin
        if (sb.size() > 0) eval_seg(c, ab);
        sb.delete();
        sc.delete();
      end else begin
        sb.push_back(s_d[c]);
        sc.push_back(c);
      end
    end
    ok = 0;
    er = 0;
    for (int c = 0; c <= n; c++) begin
      if (c < n && s_rst[c]) begin
        ok = 0;
        er = 0;
      end else if (e_eof[c]) begin
        if (e_el[c] || e_ec[c]) er++;
        else                    ok++;
      end
      e_ok[c] = 16'(ok);
      e_er[c] = 16'(er);
    end
  endtask

  task automatic compare(input int c);
    chk("valid", c, 32'(out_valid), 32'(e_v[c]));
    chk("sof", c, 32'(out_sof), 32'(e_sof[c]));
    chk("eof", c, 32'(out_eof), 32'(e_eof[c]));
    chk("cnt_ok", c, 32'(cnt_ok), 32'(e_ok[c]));
    chk("cnt_err", c, 32'(cnt_err), 32'(e_er[c]));
    if (e_v[c]) chk("data", c, 32'(out_data), 32'(e_d[c]));
    if (e_eof[c]) begin
      chk("len", c, 32'(out_len), 32'(e_len[c]));
      chk("err_len", c, 32'(out_err_len), 32'(e_el[c]));
      chk("err_crc", c, 32'(out_err_crc), 32'(e_ec[c]));
    end
    if (out_valid === 1'b1) obs_valid++;
    if (out_valid === 1'b1 && out_eof === 1'b1) begin
      obs_len.push_back(int'(out_len));
      obs_el.push_back(int'(out_err_len));
    end
  endtask

  int exp_len[6];
  int exp_el[6];

  initial begin
    rst = 1'b1;
    dv  = 1'b0;
    rxd = 8'h00;

    for (int i = 0; i < 3; i++) add(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 2; i++) add(1'b0, 8'h00, 1'b0);
    add_frame(64, -1, -1);
    add_frame(64, 10, -1);
    add_frame(60, -1, -1);
    for (int i = 0; i < 20; i++) add(1'b1, 8'hAA, 1'b0);
    for (int i = 0; i < 4; i++) add(1'b0, 8'h00, 1'b0);
    add_frame(64, -1, -1);
    add_frame(64, -1, 30);
    add_frame(64, -1, -1);
    add_frame(2100, -1, -1);
    for (int i = 0; i < 4; i++) add(1'b0, 8'h00, 1'b0);

    build_model();

    for (int c = 0; c < n; c++) begin
      rst = s_rst[c];
      dv  = s_dv[c];
      rxd = s_d[c];
      @(posedge clk);
      @(negedge clk);
      compare(c);
    end

    exp_len = '{64, 64, 60, 64, 64, 2047};
    exp_el  = '{0, 0, 1, 0, 0, 1};
    chk("eof_count", n, 32'(obs_len.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < obs_len.size()) begin
        chk("lit_len", i, 32'(obs_len[i]), 32'(exp_len[i]));
        chk("lit_err_len", i, 32'(obs_el[i]), 32'(exp_el[i]));
      end
    end
    chk("lit_valid_total", n, 32'(obs_valid), 32'd2445);
    chk("lit_cnt_ok", n, 32'(cnt_ok), 32'd1);
    chk("lit_cnt_err", n, 32'(cnt_err), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
